coord_mem_arbiter: RTL and testbench
====================================

Name: coord_mem_arbiter

Overview:
- Owns the single-port node coordinate RAM of the pathfinding accelerator and shares it among its users.
- During the INIT phase, the coordinate-collection path writes node (x,y) pairs into the RAM.
- After initialisation completes, NUM_RD search-engine requesters read coordinates under round-robin arbitration.
- Sequences the INIT→RUN→(re)INIT phases and flags illegal accesses.

Parameters:
NUM_RD, 2, number of read requesters (1..8)
ADDR_W, 8, node address width (RAM depth 2**ADDR_W)
COORD_W, 16, width of each of x and y

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
wr_req  input  1  collector write request; held with wr_addr/wr_x/wr_y until wr_gnt
wr_addr  input  ADDR_W  node index to write
wr_x  input  COORD_W  x coordinate
wr_y  input  COORD_W  y coordinate
wr_gnt  output  1  write accepted this cycle (combinational)
init_done  input  1  pulse: coordinate entry finished
reinit  input  1  pulse: return to INIT for a new map
rd_req  input  NUM_RD  per-requester read request; held with address until granted
rd_addr  input  NUM_RD*ADDR_W  flattened read addresses; requester i at [i*ADDR_W +: ADDR_W]
rd_gnt  output  NUM_RD  one-hot read grant (combinational)
rd_valid  output  NUM_RD  one-hot; rd_x/rd_y valid for that requester
rd_x  output  COORD_W  read x, shared bus
rd_y  output  COORD_W  read y, shared bus
mem_en  output  1  RAM enable
mem_we  output  1  RAM write enable
mem_addr  output  ADDR_W  RAM address
mem_wdata  output  2*COORD_W  {x,y} write data
mem_rdata  input  2*COORD_W  {x,y}; valid 1 cycle after mem_en with mem_we=0
run_mode  output  1  high in RUN
node_count  output  ADDR_W+1  writes granted since last INIT entry, saturating at 2**ADDR_W
wr_err  output  1  sticky: wr_req seen outside INIT

Behaviour:
- Reset values:
  - State INIT; round-robin pointer set so requester 0 has highest priority.
  - All outputs 0: wr_gnt, rd_gnt, rd_valid, rd_x, rd_y, mem_*, run_mode, node_count, wr_err.
- State INIT:
  - wr_gnt = wr_req. When granted: mem_en=1, mem_we=1, mem_addr=wr_addr, mem_wdata={wr_x,wr_y}.
  - rd_gnt is held at 0.
  - Each write grant increments node_count, saturating at 2**ADDR_W.
- INIT→RUN on init_done.
  - A write presented in the same cycle as init_done is still granted.
  - run_mode=1 from the next cycle.
  - init_done in RUN is ignored.
- State RUN:
  - At most one read grant per cycle.
  - Winner: the first requesting index starting at (last_granted+1) mod NUM_RD.
  - Pointer updates to the winner only on a grant.
  - Granted: mem_en=1, mem_we=0, mem_addr=rd_addr of winner.
- Read latency is 1 cycle: cycle after a grant, rd_valid[winner]=1 and {rd_x,rd_y}=mem_rdata.
  - rd_x/rd_y hold their last value otherwise.
  - Back-to-back grants give a continuous rd_valid stream.
- wr_req in RUN is never granted; it sets wr_err, which clears only on reset.
- RUN→INIT on reinit:
  - No read is granted in the reinit cycle.
  - A read granted the previous cycle still produces its rd_valid.
  - node_count clears to 0 on entry to INIT; run_mode drops next cycle.
  - The round-robin pointer is preserved.
  - reinit in INIT is ignored.
- init_done and reinit together: init_done wins in INIT, reinit wins in RUN.
- mem_en=0 whenever no grant is issued.
- Async reset mid-transaction drops everything immediately; no rd_valid follows a grant cut off by reset.

Test Plan:
- Reset, then 3 writes (addr 0,1,2; x=10,20,30; y=5,6,7) → wr_gnt each cycle with mem_we=1 and correct mem_wdata; node_count=3; rd_req asserted throughout gets no rd_gnt.
- init_done coincident with a write to addr 3 → write granted and node_count=4; run_mode=1 next cycle; a later wr_req raises wr_err permanently.
- RUN, rd_req=2'b11 held continuously → grants alternate 01,10,01,10; each rd_valid one cycle later carries mem_rdata of the matching address.
- RUN, only requester 1 requests for 3 cycles, then both → three grants to 1, then grant to 0 (pointer follows last winner).
- reinit in the cycle after a read grant → rd_valid still delivered; no grant in the reinit cycle; node_count=0; a new write is granted in INIT.
- Async reset asserted mid-read-stream → all outputs 0 immediately, no stale rd_valid; state INIT on release.

Source files
------------

// File: rtl/coord_mem_arbiter.sv
// Node coordinate RAM owner: the collector writes (x,y) pairs during INIT, then
// NUM_RD search engines share read access under round-robin arbitration in RUN.
module coord_mem_arbiter #(
  parameter int NUM_RD  = 2,
  parameter int ADDR_W  = 8,
  parameter int COORD_W = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_req,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [COORD_W-1:0]          wr_x,
  input  logic [COORD_W-1:0]          wr_y,
  output logic                        wr_gnt,
  input  logic                        init_done,
  input  logic                        reinit,
  input  logic [NUM_RD-1:0]           rd_req,
  input  logic [NUM_RD*ADDR_W-1:0]    rd_addr,
  output logic [NUM_RD-1:0]           rd_gnt,
  output logic [NUM_RD-1:0]           rd_valid,
  output logic [COORD_W-1:0]          rd_x,
  output logic [COORD_W-1:0]          rd_y,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [2*COORD_W-1:0]        mem_wdata,
  input  logic [2*COORD_W-1:0]        mem_rdata,
  output logic                        run_mode,
  output logic [ADDR_W:0]             node_count,
  output logic                        wr_err
);

  // Handshake: a requester holds req (and its address/data) until the
  // combinational grant is seen; grant means the RAM access happens in that
  // same cycle. For reads, rd_valid pulses exactly one cycle after the grant
  // and rd_x/rd_y carry the RAM data while it is high, holding otherwise.

  localparam int PTR_W = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [PTR_W-1:0]       last_q, last_d;
  logic [ADDR_W:0]        node_count_q, node_count_d;
  logic                   wr_err_q, wr_err_d;
  logic [NUM_RD-1:0]      rd_valid_q, rd_valid_d;
  logic [2*COORD_W-1:0]   rd_hold_q, rd_hold_d;

  logic                   win_found;
  logic [PTR_W-1:0]       win_idx;
  logic [PTR_W-1:0]       cand;
  logic                   rd_grant;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state. init_done only matters in INIT, reinit only in RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: if (init_done) state_d = ST_RUN;
      ST_RUN:  if (reinit)    state_d = ST_INIT;
      default: state_d = ST_INIT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Round-robin search starting just after the last winner
  // ---------------------------------------------------------------------------
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_RD; k++) begin
      cand = PTR_W'((int'(last_q) + k) % NUM_RD);
      if (!win_found && rd_req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign rd_grant = (state_q == ST_RUN) && !reinit && win_found;

  // ---------------------------------------------------------------------------
  // FSM: outputs. Forced low while reset is asserted so nothing leaks out.
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_gnt    = 1'b0;
    rd_gnt    = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!reset) begin
      if (state_q == ST_INIT) begin
        if (wr_req) begin
          wr_gnt    = 1'b1;
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = wr_addr;
          mem_wdata = {wr_x, wr_y};
        end
      end else if (rd_grant) begin
        rd_gnt[win_idx] = 1'b1;
        mem_en          = 1'b1;
        mem_addr        = rd_addr[win_idx*ADDR_W +: ADDR_W];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath / bookkeeping next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    last_d = last_q;
    if (|rd_gnt) begin
      last_d = win_idx;
    end
  end

  // Count is cleared on the way back to INIT so it reflects the new map only.
  always_comb begin
    node_count_d = node_count_q;
    if ((state_q == ST_RUN) && reinit) begin
      node_count_d = '0;
    end else if (wr_gnt && (node_count_q != CNT_MAX)) begin
      node_count_d = node_count_q + 1'b1;
    end
  end

  always_comb begin
    wr_err_d = wr_err_q;
    if ((state_q == ST_RUN) && wr_req) begin
      wr_err_d = 1'b1;
    end
  end

  always_comb begin
    rd_valid_d = rd_gnt;
    rd_hold_d  = rd_hold_q;
    if (|rd_valid_q) begin
      rd_hold_d = mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q       <= PTR_W'(NUM_RD - 1);
      node_count_q <= '0;
      wr_err_q     <= 1'b0;
      rd_valid_q   <= '0;
      rd_hold_q    <= '0;
    end else begin
      last_q       <= last_d;
      node_count_q <= node_count_d;
      wr_err_q     <= wr_err_d;
      rd_valid_q   <= rd_valid_d;
      rd_hold_q    <= rd_hold_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output assignments
  // ---------------------------------------------------------------------------
  // RAM data is passed straight through in the valid cycle and held afterwards.
  assign rd_valid   = rd_valid_q;
  assign rd_x       = (|rd_valid_q) ? mem_rdata[2*COORD_W-1:COORD_W] : rd_hold_q[2*COORD_W-1:COORD_W];
  assign rd_y       = (|rd_valid_q) ? mem_rdata[COORD_W-1:0]         : rd_hold_q[COORD_W-1:0];
  assign run_mode   = (state_q == ST_RUN);
  assign node_count = node_count_q;
  assign wr_err     = wr_err_q;

endmodule

// File: tb/tb_coord_mem_arbiter.sv
// Bench for coord_mem_arbiter: directed phase/arbitration scenarios plus random
// traffic, checked against an abstract model with a read-data scoreboard.
module tb_coord_mem_arbiter;

  localparam int NUM_RD  = 2;
  localparam int ADDR_W  = 8;
  localparam int COORD_W = 16;
  localparam int DEPTH   = 1 << ADDR_W;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic                      wr_req = 1'b0;
  logic [ADDR_W-1:0]         wr_addr = '0;
  logic [COORD_W-1:0]        wr_x = '0;
  logic [COORD_W-1:0]        wr_y = '0;
  logic                      wr_gnt;
  logic                      init_done = 1'b0;
  logic                      reinit = 1'b0;
  logic [NUM_RD-1:0]         rd_req = '0;
  logic [NUM_RD*ADDR_W-1:0]  rd_addr = '0;
  logic [NUM_RD-1:0]         rd_gnt;
  logic [NUM_RD-1:0]         rd_valid;
  logic [COORD_W-1:0]        rd_x, rd_y;
  logic                      mem_en, mem_we;
  logic [ADDR_W-1:0]         mem_addr;
  logic [2*COORD_W-1:0]      mem_wdata;
  logic [2*COORD_W-1:0]      mem_rdata = '0;
  logic                      run_mode;
  logic [ADDR_W:0]           node_count;
  logic                      wr_err;

  coord_mem_arbiter #(.NUM_RD(NUM_RD), .ADDR_W(ADDR_W), .COORD_W(COORD_W)) dut (
    .clk(clk), .reset(reset),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_x(wr_x), .wr_y(wr_y), .wr_gnt(wr_gnt),
    .init_done(init_done), .reinit(reinit),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid),
    .rd_x(rd_x), .rd_y(rd_y),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .run_mode(run_mode), .node_count(node_count), .wr_err(wr_err)
  );

  // Single-port RAM with one cycle read latency
  logic [2*COORD_W-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard
  // ---------------------------------------------------------------------------
  int                    m_phase;   // 0 = INIT, 1 = RUN
  int                    m_ptr;     // last granted requester
  int                    m_count;
  int                    m_err;
  logic [2*COORD_W-1:0]  m_mem [DEPTH];
  logic [39:0]           exp_q [$]; // {requester, x, y}
  int                    due_q [$];
  logic [COORD_W-1:0]    last_x, last_y;
  int                    n_tests = 0;
  int                    n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_ptr   = NUM_RD - 1;
    m_count = 0;
    m_err   = 0;
    last_x  = '0;
    last_y  = '0;
    exp_q.delete();
    due_q.delete();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_wr_gnt"},     wr_gnt, 0);
    chk({tag, "_rd_gnt"},     rd_gnt, 0);
    chk({tag, "_rd_valid"},   rd_valid, 0);
    chk({tag, "_rd_x"},       rd_x, 0);
    chk({tag, "_rd_y"},       rd_y, 0);
    chk({tag, "_mem_en"},     mem_en, 0);
    chk({tag, "_mem_we"},     mem_we, 0);
    chk({tag, "_mem_addr"},   mem_addr, 0);
    chk({tag, "_mem_wdata"},  mem_wdata, 0);
    chk({tag, "_run_mode"},   run_mode, 0);
    chk({tag, "_node_count"}, node_count, 0);
    chk({tag, "_wr_err"},     wr_err, 0);
  endtask

  // One clock cycle with the currently driven inputs: check, then advance model.
  task automatic step();
    int win;
    int i;
    logic [ADDR_W-1:0] ra;
    @(negedge clk);
    win = -1;
    if (m_phase == 1 && !reinit) begin
      for (int k = 1; k <= NUM_RD; k++) begin
        i = (m_ptr + k) % NUM_RD;
        if (win < 0 && rd_req[i]) win = i;
      end
    end
    chk("wr_gnt", wr_gnt, (m_phase == 0) && wr_req);
    chk("rd_gnt", rd_gnt, (win < 0) ? 0 : (1 << win));
    chk("run_mode", run_mode, m_phase);
    chk("node_count", node_count, m_count);
    chk("wr_err", wr_err, m_err);
    if (m_phase == 0 && wr_req) begin
      chk("wr_mem_en", mem_en, 1);
      chk("wr_mem_we", mem_we, 1);
      chk("wr_mem_addr", mem_addr, wr_addr);
      chk("wr_mem_wdata", mem_wdata, {wr_x, wr_y});
    end else if (win >= 0) begin
      ra = rd_addr[win*ADDR_W +: ADDR_W];
      chk("rd_mem_en", mem_en, 1);
      chk("rd_mem_we", mem_we, 0);
      chk("rd_mem_addr", mem_addr, ra);
      exp_q.push_back({8'(win), m_mem[ra]});
      due_q.push_back(cyc + 1);
    end else begin
      chk("idle_mem_en", mem_en, 0);
    end
    @(posedge clk);
    if (m_phase == 0) begin
      if (wr_req) begin
        m_mem[wr_addr] = {wr_x, wr_y};
        if (m_count < DEPTH) m_count++;
      end
      if (init_done) m_phase = 1;
    end else begin
      if (wr_req) m_err = 1;
      if (reinit) begin
        m_phase = 0;
        m_count = 0;
      end else if (win >= 0) begin
        m_ptr = win;
      end
    end
    #1;
  endtask

  task automatic idle();
    wr_req = 1'b0; init_done = 1'b0; reinit = 1'b0; rd_req = '0;
  endtask

  task automatic set_wr(input int a, input int x, input int y);
    wr_req = 1'b1; wr_addr = ADDR_W'(a); wr_x = COORD_W'(x); wr_y = COORD_W'(y);
  endtask

  // Monitor: pops the scoreboard whenever a read result is presented
  always @(negedge clk) begin
    logic [39:0] e;
    int d;
    if (!reset) begin
      if (rd_valid != '0) begin
        if (exp_q.size() == 0) begin
          chk("rd_valid_unexpected", rd_valid, 0);
        end else begin
          e = exp_q.pop_front();
          d = due_q.pop_front();
          chk("rd_latency", cyc, d);
          chk("rd_valid", rd_valid, 1 << e[39:32]);
          chk("rd_x", rd_x, e[31:16]);
          chk("rd_y", rd_y, e[15:0]);
          last_x = e[31:16];
          last_y = e[15:0];
        end
      end else begin
        chk("rd_x_hold", rd_x, last_x);
        chk("rd_y_hold", rd_y, last_y);
      end
      while (due_q.size() > 0 && due_q[0] <= cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL rd_valid_missing: no rd_valid at cycle %0d for requester %0d", cyc, exp_q[0][39:32]);
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    for (int a = 0; a < DEPTH; a++) begin
      ram[a]   = '0;
      m_mem[a] = '0;
    end
    model_reset();

    // Reset: outputs low even with requests present
    wr_req = 1'b1; rd_req = '1;
    #12;
    check_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    idle();

    // Three writes in INIT while both readers request
    rd_req = '1;
    rd_addr = {8'd1, 8'd0};
    set_wr(0, 10, 5); step();
    set_wr(1, 20, 6); step();
    set_wr(2, 30, 7); step();

    // Write coincident with init_done, then an illegal write in RUN
    set_wr(3, 40, 8); init_done = 1'b1; rd_req = '0; step();
    idle(); step();
    set_wr(9, 1, 1); step();
    idle(); step();

    // Both readers continuously: alternating grants
    rd_addr = {8'd1, 8'd0};
    rd_req = 2'b11;
    repeat (4) step();

    // Requester 1 alone for 3 cycles, then both
    rd_addr = {8'd3, 8'd2};
    rd_req = 2'b10;
    repeat (3) step();
    rd_req = 2'b11;
    step();

    // reinit right after a grant
    rd_req = 2'b11; step();
    reinit = 1'b1; step();
    idle(); set_wr(5, 55, 66); step();
    idle(); step();

    // Fill beyond the RAM depth to hit the count saturation
    for (int a = 0; a < DEPTH + 3; a++) begin
      set_wr(a % DEPTH, $urandom_range(0, 65535), $urandom_range(0, 65535));
      step();
    end
    idle(); step();

    // Random traffic across phases
    for (int n = 0; n < 400; n++) begin
      idle();
      rd_req = NUM_RD'($urandom_range(0, (1 << NUM_RD) - 1));
      for (int r = 0; r < NUM_RD; r++)
        rd_addr[r*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, DEPTH - 1));
      if (m_phase == 0) begin
        if ($urandom_range(0, 1) == 1)
          set_wr($urandom_range(0, DEPTH - 1), $urandom_range(0, 65535), $urandom_range(0, 65535));
        init_done = ($urandom_range(0, 9) == 0);
        reinit    = ($urandom_range(0, 4) == 0);
      end else begin
        reinit    = ($urandom_range(0, 14) == 0);
        init_done = ($urandom_range(0, 4) == 0);
        if ($urandom_range(0, 39) == 0)
          set_wr($urandom_range(0, DEPTH - 1), 7, 7);
      end
      step();
    end

    // Reset in the middle of a read stream
    idle(); step();
    if (m_phase == 0) begin
      init_done = 1'b1; step(); idle();
    end
    rd_addr = {8'd1, 8'd2};
    rd_req = 2'b11;
    repeat (3) step();
    reset = 1'b1;
    #1;
    check_zero("async_reset");
    model_reset();
    @(posedge clk); #2;
    reset = 1'b0;
    idle();
    rd_req = 2'b11;
    repeat (2) step();
    idle();
    repeat (3) step();

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
